// File: rtl/fe_de_buffer_if.sv
// Fetch-to-decode handshake bundle: fetch push side, decode pop side, flush and occupancy.
// The master modport is the environment driving fetch/decode; the buffer itself is the slave.
interface fe_de_buffer_if #(
  parameter int DEPTH = 2
);
  logic                     flush;
  logic                     fe_valid;
  logic [31:0]              fe_inst;
  logic [31:0]              fe_pc;
  logic                     fe_ready;
  logic                     de_valid;
  logic [31:0]              de_inst;
  logic [31:0]              de_pc;
  logic [31:0]              de_pc_plus4;
  logic                     de_ready;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output flush, fe_valid, fe_inst, fe_pc, de_ready,
    input  fe_ready, de_valid, de_inst, de_pc, de_pc_plus4, count
  );

  modport slave (
    input  flush, fe_valid, fe_inst, fe_pc, de_ready,
    output fe_ready, de_valid, de_inst, de_pc, de_pc_plus4, count
  );
endinterface

// File: rtl/fe_de_buffer.sv
// Elastic fetch/decode buffer: in-order queue of {inst, pc} with registered-only fe_ready,
// no empty bypass, and a synchronous flush that drops every buffered entry.
module fe_de_buffer #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  fe_de_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      inst_arr [DEPTH];
  logic [31:0]      pc_arr   [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fe_ready;
  logic             de_valid;
  logic             push;
  logic             pop;

  // fe_ready comes from the occupancy register only, keeping decode off the fetch enable path
  assign fe_ready = (count_q < FULL_CNT);
  assign de_valid = (count_q != '0);
  assign push     = bus.fe_valid && fe_ready && !bus.flush;
  assign pop      = de_valid && bus.de_ready && !bus.flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // One register pair per slot; flush leaves contents alone, only reset scrubs them
  for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
    logic [31:0] inst_q;
    logic [31:0] pc_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        inst_q <= NOP_INST;
        pc_q   <= '0;
      end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
        inst_q <= bus.fe_inst;
        pc_q   <= bus.fe_pc;
      end
    end

    assign inst_arr[gi] = inst_q;
    assign pc_arr[gi]   = pc_q;
  end

  assign bus.fe_ready    = fe_ready;
  assign bus.de_valid    = de_valid;
  assign bus.de_inst     = de_valid ? inst_arr[rd_ptr_q] : NOP_INST;
  assign bus.de_pc       = de_valid ? pc_arr[rd_ptr_q] : 32'd0;
  assign bus.de_pc_plus4 = bus.de_pc + 32'd4;
  assign bus.count       = count_q;
endmodule
